// File: rtl/sr_latch_ctrl.sv
// rtl/sr_latch_ctrl.sv - round-robin sequencer driving set/reset pulses into an SR latch bank
//
// Serializes per-requester set/reset requests onto one latch at a time as
// PULSE_CYC-wide s/r pulses, waits SETTLE_CYC quiet cycles, then acks.
// Optional macro: SR_LATCH_CTRL_VERIFY_EN enables the q_in readback check
// that drives the sticky err flag.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      per-requester level request, held until ack
//   op       per-requester operation (1 = set, 0 = reset)
//   idx      per-requester latch index, requester k at [k*IDXW +: IDXW]
//   q_in     latch bank q readback
//   s_out    set drive, at most one bit high
//   r_out    reset drive, at most one bit high, never with s_out
//   ack      one-cycle completion pulse to the served requester
//   bad_idx  one-cycle pulse with ack when the served idx >= NFLAGS
//   busy     high whenever the sequencer is not idle
//   err      sticky readback mismatch flag

module sr_latch_ctrl #(
    parameter int NREQ       = 4,
    parameter int NFLAGS     = 8,
    parameter int IDXW       = 3,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*IDXW-1:0] idx,
    input  logic [NFLAGS-1:0]    q_in,
    output logic [NFLAGS-1:0]    s_out,
    output logic [NFLAGS-1:0]    r_out,
    output logic [NREQ-1:0]      ack,
    output logic                 bad_idx,
    output logic                 busy,
    output logic                 err
);

    localparam int RRW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [IDXW:0] NFL_W = (IDXW + 1)'(NFLAGS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [RRW-1:0]  rr;
    logic [RRW-1:0]  win;
    logic            w_bad;

    // Round-robin search starting at rr, wrapping modulo NREQ
    logic            grant_any;
    logic [RRW-1:0]  grant_id;

    always_comb begin
        int k;
        grant_any = 1'b0;
        grant_id  = '0;
        k         = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(rr) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (!grant_any && req[k]) begin
                grant_any = 1'b1;
                grant_id  = RRW'(k);
            end
        end
    end

    logic              g_op;
    logic [IDXW-1:0]   g_idx;
    logic              g_bad;
    logic [NFLAGS-1:0] g_hot;

    always_comb begin
        g_op  = op[grant_id];
        g_idx = idx[int'(grant_id) * IDXW +: IDXW];
        g_bad = ({1'b0, g_idx} >= NFL_W);
        g_hot = '0;
        for (int f = 0; f < NFLAGS; f++) begin
            g_hot[f] = (g_idx == IDXW'(f));
        end
    end

    // The ack is registered, so it is launched on the edge that enters the
    // final SETTLE cycle. A bad index with a one-cycle settle fires straight
    // out of IDLE, using the live grant instead of the registered winner.
    logic            fire;
    logic [RRW-1:0]  fire_id;
    logic            fire_bad;
    logic [NREQ-1:0] fire_hot;

    always_comb begin
        fire     = 1'b0;
        fire_id  = win;
        fire_bad = w_bad;
        case (state)
            ST_IDLE: begin
                fire     = grant_any && g_bad && (SETTLE_CYC == 1);
                fire_id  = grant_id;
                fire_bad = 1'b1;
            end
            ST_PULSE:  fire = (cnt == '0) && (SETTLE_CYC == 1);
            ST_SETTLE: fire = (cnt == CW'(1));
            default:   fire = 1'b0;
        endcase
        fire_hot = '0;
        for (int i = 0; i < NREQ; i++) begin
            fire_hot[i] = fire && (fire_id == RRW'(i));
        end
    end

    logic [RRW-1:0] rr_next;
    assign rr_next = (win == RRW'(NREQ - 1)) ? '0 : win + RRW'(1);

    assign busy = (state != ST_IDLE);

`ifdef SR_LATCH_CTRL_VERIFY_EN
    logic            w_op;
    logic [IDXW-1:0] w_idx;
    logic            q_sel;

    always_comb begin
        q_sel = 1'b0;
        for (int f = 0; f < NFLAGS; f++) begin
            if (w_idx == IDXW'(f)) begin
                q_sel = q_in[f];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_op  <= 1'b0;
            w_idx <= '0;
            err   <= 1'b0;
        end else begin
            if (state == ST_IDLE && grant_any) begin
                w_op  <= g_op;
                w_idx <= g_idx;
            end
            // Latch has been driven for the whole pulse by the time this fires
            if (fire && !fire_bad && (q_sel != w_op)) begin
                err <= 1'b1;
            end
        end
    end
`else
    logic unused_q;
    assign unused_q = ^q_in;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rr      <= '0;
            win     <= '0;
            w_bad   <= 1'b0;
            s_out   <= '0;
            r_out   <= '0;
            ack     <= '0;
            bad_idx <= 1'b0;
        end else begin
            ack     <= fire_hot;
            bad_idx <= fire && fire_bad;
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        win   <= grant_id;
                        w_bad <= g_bad;
                        if (g_bad) begin
                            state <= ST_SETTLE;
                            cnt   <= CW'(SETTLE_CYC - 1);
                        end else begin
                            state <= ST_PULSE;
                            cnt   <= CW'(PULSE_CYC - 1);
                            s_out <= g_op ? g_hot : '0;
                            r_out <= g_op ? '0 : g_hot;
                        end
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        state <= ST_SETTLE;
                        cnt   <= CW'(SETTLE_CYC - 1);
                        s_out <= '0;
                        r_out <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        rr    <= rr_next;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    s_out <= '0;
                    r_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb/tb_sr_latch_ctrl.sv - scoreboard bench for sr_latch_ctrl

module tb_sr_latch_ctrl;

    localparam int NREQ   = 4;
    localparam int NFLAGS = 6;
    localparam int IDXW   = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ-1:0]      op = '0;
    logic [NREQ*IDXW-1:0] idx = '0;
    logic [NFLAGS-1:0]    q_in;
    logic [NFLAGS-1:0]    s_out;
    logic [NFLAGS-1:0]    r_out;
    logic [NREQ-1:0]      ack;
    logic                 bad_idx;
    logic                 busy;
    logic                 err;

    logic [NFLAGS-1:0]    qm = '0;
    logic [NFLAGS-1:0]    qmask = '0;

    int checks = 0;
    int failures = 0;
    int acks_seen = 0;

    typedef struct {
        logic [NREQ-1:0]   ack;
        logic              bad;
        logic [NFLAGS-1:0] s;
        logic [NFLAGS-1:0] r;
        int                pcyc;
        int                bcyc;
    } exp_t;

    exp_t sb[$];

    sr_latch_ctrl #(
        .NREQ      (NREQ),
        .NFLAGS    (NFLAGS),
        .IDXW      (IDXW),
        .PULSE_CYC (2),
        .SETTLE_CYC(1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .op     (op),
        .idx    (idx),
        .q_in   (q_in),
        .s_out  (s_out),
        .r_out  (r_out),
        .ack    (ack),
        .bad_idx(bad_idx),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) qm <= (qm | s_out) & ~r_out;
    assign q_in = qm & ~qmask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [NREQ-1:0] a, input logic b, input logic [NFLAGS-1:0] s,
                        input logic [NFLAGS-1:0] r, input int pc, input int bc);
        exp_t e;
        e.ack = a; e.bad = b; e.s = s; e.r = r; e.pcyc = pc; e.bcyc = bc;
        sb.push_back(e);
    endtask

    task automatic set_ch(input int k, input logic o, input logic [IDXW-1:0] v);
        op[k] = o;
        idx[k*IDXW +: IDXW] = v;
    endtask

    // Hold req=mask until n acks arrive, then drop it in the following idle cycle
    task automatic issue(input logic [NREQ-1:0] mask, input int n);
        int target;
        target = acks_seen + n;
        req = mask;
        for (int c = 0; c < 40 * n && acks_seen < target; c++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (acks_seen < target) begin
            failures++;
            $display("FAIL ack_timeout: got %0d acks expected %0d", acks_seen, target);
        end
        req = '0;
    endtask

    // Monitor: invariants every cycle, scoreboard compare on every ack
    initial begin
        logic [NFLAGS-1:0] acc_s;
        logic [NFLAGS-1:0] acc_r;
        int pcyc;
        int bcyc;
        exp_t e;
        acc_s = '0; acc_r = '0; pcyc = 0; bcyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc_s = '0; acc_r = '0; pcyc = 0; bcyc = 0;
            end else begin
                checks++;
                if ((s_out & r_out) != '0 || $countones(s_out | r_out) > 1) begin
                    failures++;
                    $display("FAIL drive_invariant: s=%b r=%b", s_out, r_out);
                end
                if (busy) bcyc++;
                acc_s = acc_s | s_out;
                acc_r = acc_r | r_out;
                if ((s_out | r_out) != '0) pcyc++;
                if (bad_idx && ack == '0) begin
                    checks++;
                    failures++;
                    $display("FAIL bad_without_ack: bad_idx=1 ack=%b", ack);
                end
                if (ack != '0) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_ack: got %b expected none", ack);
                    end else begin
                        e = sb.pop_front();
                        chk("ack", 32'(ack), 32'(e.ack));
                        chk("bad_idx", 32'(bad_idx), 32'(e.bad));
                        chk("s_pattern", 32'(acc_s), 32'(e.s));
                        chk("r_pattern", 32'(acc_r), 32'(e.r));
                        chk("pulse_cycles", 32'(pcyc), 32'(e.pcyc));
                        chk("busy_cycles", 32'(bcyc), 32'(e.bcyc));
                    end
                    acks_seen++;
                    acc_s = '0; acc_r = '0; pcyc = 0; bcyc = 0;
                end
            end
        end
    end

    initial begin
        logic exp_err;
`ifdef SR_LATCH_CTRL_VERIFY_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_out", 32'(s_out), 32'h0);
        chk("rst_r_out", 32'(r_out), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_bad_idx", 32'(bad_idx), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention: all four held, rr starts at 0 -> grants 0,1,2,3,0
        set_ch(0, 1'b1, 3'd0);
        set_ch(1, 1'b0, 3'd2);
        set_ch(2, 1'b1, 3'd4);
        set_ch(3, 1'b0, 3'd1);
        push(4'b0001, 1'b0, 6'b000001, 6'b000000, 2, 3);
        push(4'b0010, 1'b0, 6'b000000, 6'b000100, 2, 3);
        push(4'b0100, 1'b0, 6'b010000, 6'b000000, 2, 3);
        push(4'b1000, 1'b0, 6'b000000, 6'b000010, 2, 3);
        push(4'b0001, 1'b0, 6'b000001, 6'b000000, 2, 3);
        issue(4'b1111, 5);

        // Reset mid-pulse (rr is 1 going in)
        set_ch(0, 1'b1, 3'd2);
        req = 4'b0001;
        @(posedge clk);
        #1;
        chk("pulse_started", 32'(s_out), 32'(6'b000100));
        rst_n = 1'b0;
        #1;
        chk("async_s_out", 32'(s_out), 32'h0);
        chk("async_r_out", 32'(r_out), 32'h0);
        chk("async_ack", 32'(ack), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        req = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // rr back to 0: requesters 0 and 3 -> 0 served before 3
        set_ch(3, 1'b0, 3'd3);
        push(4'b0001, 1'b0, 6'b000100, 6'b000000, 2, 3);
        push(4'b1000, 1'b0, 6'b000000, 6'b001000, 2, 3);
        issue(4'b1001, 2);

        // Single set request, idx 3
        set_ch(0, 1'b1, 3'd3);
        push(4'b0001, 1'b0, 6'b001000, 6'b000000, 2, 3);
        issue(4'b0001, 1);

        // Reset op on requester 2, highest valid index
        set_ch(2, 1'b0, 3'd5);
        push(4'b0100, 1'b0, 6'b000000, 6'b100000, 2, 3);
        issue(4'b0100, 1);

        // Bad indices: 7 and the boundary value 6
        set_ch(1, 1'b1, 3'd7);
        push(4'b0010, 1'b1, 6'b000000, 6'b000000, 0, 1);
        issue(4'b0010, 1);
        set_ch(3, 1'b0, 3'd6);
        push(4'b1000, 1'b1, 6'b000000, 6'b000000, 0, 1);
        issue(4'b1000, 1);
        chk("err_before_verify", 32'(err), 32'h0);

        // Readback stuck low on latch 1
        qmask = 6'b000010;
        set_ch(3, 1'b1, 3'd1);
        push(4'b1000, 1'b0, 6'b000010, 6'b000000, 2, 3);
        issue(4'b1000, 1);
        chk("err_after_mismatch", 32'(err), 32'(exp_err));
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", 32'(err), 32'(exp_err));
        rst_n = 1'b0;
        #1;
        chk("err_cleared", 32'(err), 32'h0);
        qmask = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_latch_ctrl.md
# sr_latch_ctrl

Sequencing controller and round-robin arbiter sitting in front of a bank of NFLAGS cross-coupled NOR SR latches. It accepts set/reset requests from NREQ requesters and serializes them onto the latch bank's s/r inputs as clean, fixed-width pulses. It guarantees that s and r are never both high on any latch, and that at most one latch is driven at a time. Each request completes with a one-cycle acknowledge after a settle interval.

## Interface
- NREQ, 4: number of requesters (≥2).
- NFLAGS, 8: number of SR latches in the bank.
- IDXW, 3: width of each latch index; 2^IDXW ≥ NFLAGS.
- PULSE_CYC, 2: cycles s or r is held high (≥1).
- SETTLE_CYC, 1: quiet cycles after the pulse before ack (≥1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester level request, held until its ack.
- op  in  NREQ  per-requester operation: 1 = set, 0 = reset.
- idx  in  NREQ*IDXW  per-requester latch index; requester k uses bits [k*IDXW +: IDXW].
- q_in  in  NFLAGS  q outputs read back from the latch bank.
- s_out  out  NFLAGS  set drive to the latch bank.
- r_out  out  NFLAGS  reset drive to the latch bank.
- ack  out  NREQ  one-cycle completion pulse to the granted requester.
- bad_idx  out  1  one-cycle pulse, coincident with ack, when the granted idx ≥ NFLAGS.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky readback mismatch flag (see Configuration).

## Operation
- Reset values: s_out = 0, r_out = 0, ack = 0, bad_idx = 0, busy = 0, err = 0, state = IDLE, rr pointer = 0.
- Reset is asynchronous. Asserting rst_n low mid-pulse drops s_out/r_out immediately. The latch keeps whatever state it reached.
- States: IDLE, PULSE, SETTLE.
- IDLE:
  - If any req bit is high, grant the first requester at or after the rr pointer, searching upward and wrapping modulo NREQ.
  - Register the winner's id, op and idx.
  - Load cnt = PULSE_CYC-1 and go to PULSE.
  - If the registered idx ≥ NFLAGS, go directly to SETTLE instead, with cnt = SETTLE_CYC-1.
- PULSE:
  - Drive s_out[idx] = op and r_out[idx] = ~op. All other bits stay 0.
  - Decrement cnt. When cnt = 0, go to SETTLE with cnt = SETTLE_CYC-1.
- SETTLE:
  - s_out and r_out are all 0. Decrement cnt.
  - When cnt = 0: assert ack[winner] for that cycle, plus bad_idx if applicable.
  - Set rr pointer = (winner+1) mod NREQ and return to IDLE.
- Invariant: (s_out & r_out) == 0 and popcount(s_out | r_out) ≤ 1 in every cycle.
- Request changes while busy are ignored. op and idx are sampled only at grant.
- A req still high in the cycle after its ack is treated as a new request.
- The rotating pointer gives the just-served requester the lowest priority, so no requester starves.

## Timing
- Request high in IDLE at edge 0:
  - s/r are high for edges 1..PULSE_CYC.
  - SETTLE covers edges PULSE_CYC+1..PULSE_CYC+SETTLE_CYC.
  - ack is high during the last SETTLE cycle.
  - Total latency: PULSE_CYC+SETTLE_CYC+1 cycles from grant to IDLE.
- Bad-index request: ack occurs SETTLE_CYC cycles after grant, with no pulse.
- Back-to-back requests: the next grant can occur in the IDLE cycle immediately after ack. Per-request throughput is PULSE_CYC+SETTLE_CYC+1 cycles.

## Configuration
- SR_LATCH_CTRL_VERIFY_EN defined:
  - In the final SETTLE cycle of a valid-index request, compare q_in[idx] with op.
  - On mismatch, set err, which stays high until reset.
- Not defined: err is tied to 0, q_in is unused, and there is no compare logic.

## Test plan
- Single request, defaults: req[0]=1, op[0]=1, idx=3.
  - s_out = 8'b0000_1000 for 2 cycles, then 1 quiet cycle.
  - ack[0] pulses at cycle 3. busy is high for cycles 1–3.
- Contention: req = 4'b1111 with distinct idx values, held across acks.
  - Grants occur in order 0,1,2,3,0.
  - Never two latches driven at once. s_out & r_out is always 0.
- Reset op: op[2]=0, idx=5. r_out[5] high for PULSE_CYC cycles, s_out stays 0, ack[2] pulses.
- Bad index: NFLAGS=6, idx=7. No s/r activity; ack and bad_idx pulse together after SETTLE_CYC cycles.
- Reset mid-pulse: rst_n=0 on the first PULSE cycle.
  - s_out/r_out/ack go to 0 immediately.
  - After release, the rr pointer is 0 and the state is IDLE.
- VERIFY_EN: set idx=1 with q_in[1] held at 0. err rises in the ack cycle and stays high until rst_n.
